// File: rtl/varredura_displays_if.sv
// varredura_displays_if: scan-control inputs and display-pin outputs of the 7-segment scanner
interface varredura_displays_if #(
  parameter int N_DIG = 4,
  parameter int SEG_W = 8
);
  localparam int CW = N_DIG > 1 ? $clog2(N_DIG) : 1;
  logic                   en;
  logic [N_DIG*SEG_W-1:0] digit_data;
  logic [N_DIG-1:0]       digit_mask;
  logic [N_DIG-1:0]       anodes;
  logic [SEG_W-1:0]       segs;
  logic [CW-1:0]          cur_digit;
  logic                   frame_start;
  modport master (output en, digit_data, digit_mask, input anodes, segs, cur_digit, frame_start);
  modport slave  (input en, digit_data, digit_mask, output anodes, segs, cur_digit, frame_start);
endinterface

// File: rtl/varredura_displays.sv
// varredura_displays: time-multiplexed one-hot digit scanner with dwell, blank gap, skip mask and frame-atomic data
module varredura_displays #(
  parameter int N_DIG         = 4,
  parameter int SEG_W         = 8,
  parameter int DWELL         = 3,
  parameter int BLANK         = 1,
  parameter bit AN_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  varredura_displays_if.slave bus
);
  localparam int CW    = N_DIG > 1 ? $clog2(N_DIG) : 1;
  localparam int MX    = DWELL > BLANK ? DWELL : BLANK;
  localparam int CNT_W = $clog2(MX + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHOW = 2'd1, S_GAP = 2'd2;
  localparam logic [N_DIG-1:0] AN_OFF = AN_ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  logic [1:0]             r_st;
  logic [CNT_W-1:0]       r_cnt;
  logic [CW-1:0]          r_cur;
  logic [N_DIG*SEG_W-1:0] r_shadow;
  logic [N_DIG-1:0]       r_an;
  logic [SEG_W-1:0]       r_segs;
  logic                   r_fs;
  logic                   w_low_ok, w_nxt_ok;
  logic [CW-1:0]          w_low, w_nxt;
  logic [N_DIG-1:0]       w_an_low, w_an_nxt;
  logic [SEG_W-1:0]       w_seg_low, w_seg_nxt;
  logic                   w_show_end, w_gap_end, w_adv, w_frame;
  // lowest unmasked digit overall and lowest unmasked digit above the current one
  always_comb begin
    w_low_ok = 1'b0;
    w_low    = '0;
    w_nxt_ok = 1'b0;
    w_nxt    = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      if (!bus.digit_mask[i]) begin
        w_low_ok = 1'b1;
        w_low    = CW'(i);
      end
      if (!bus.digit_mask[i] && CW'(i) > r_cur) begin
        w_nxt_ok = 1'b1;
        w_nxt    = CW'(i);
      end
    end
  end
  assign w_an_low   = AN_OFF ^ (N_DIG'(1) << w_low);
  assign w_an_nxt   = AN_OFF ^ (N_DIG'(1) << w_nxt);
  assign w_seg_low  = bus.digit_data[w_low*SEG_W +: SEG_W];
  assign w_seg_nxt  = r_shadow[w_nxt*SEG_W +: SEG_W];
  assign w_show_end = r_st == S_SHOW && r_cnt == CNT_W'(DWELL - 1);
  assign w_gap_end  = r_st == S_GAP && r_cnt == CNT_W'(BLANK - 1);
  assign w_adv      = bus.en && (w_gap_end || (w_show_end && BLANK == 0));
  // a frame begins either from idle or when an advance runs past the last unmasked digit
  assign w_frame    = w_low_ok && ((r_st == S_IDLE && bus.en) || (w_adv && !w_nxt_ok));
  // scan state machine: frame latch, digit advance, gap insertion and stop/blank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= S_IDLE;
      r_cnt    <= '0;
      r_cur    <= '0;
      r_shadow <= '0;
      r_an     <= AN_OFF;
      r_segs   <= '0;
      r_fs     <= 1'b0;
    end else begin
      r_fs <= w_frame;
      if (w_frame) begin
        r_st     <= S_SHOW;
        r_cnt    <= '0;
        r_cur    <= w_low;
        r_shadow <= bus.digit_data;
        r_an     <= w_an_low;
        r_segs   <= w_seg_low;
      end else if (w_adv && w_nxt_ok) begin
        r_st   <= S_SHOW;
        r_cnt  <= '0;
        r_cur  <= w_nxt;
        r_an   <= w_an_nxt;
        r_segs <= w_seg_nxt;
      end else if (!bus.en || w_adv || w_show_end) begin
        r_st   <= (bus.en && !w_adv) ? S_GAP : S_IDLE;
        r_cnt  <= '0;
        r_an   <= AN_OFF;
        r_segs <= '0;
      end else if (r_st != S_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.anodes      = r_an;
  assign bus.segs        = r_segs;
  assign bus.cur_digit   = r_cur;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_varredura_displays.sv
// tb_varredura_displays: scoreboard bench for the scanner in default, active-low/no-gap and single-digit builds
module tb_varredura_displays;
  typedef struct {
    int         u;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];
  ent_t e_chk;
  always #5 clk = ~clk;
  varredura_displays_if #(.N_DIG(4), .SEG_W(8)) bus0();
  varredura_displays_if #(.N_DIG(4), .SEG_W(8)) bus1();
  varredura_displays_if #(.N_DIG(1), .SEG_W(8)) bus2();
  varredura_displays #(.N_DIG(4), .SEG_W(8), .DWELL(3), .BLANK(1), .AN_ACTIVE_LOW(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  varredura_displays #(.N_DIG(4), .SEG_W(8), .DWELL(3), .BLANK(0), .AN_ACTIVE_LOW(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  varredura_displays #(.N_DIG(1), .SEG_W(8), .DWELL(1), .BLANK(2), .AN_ACTIVE_LOW(1'b0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_chk = sb.pop_front();
      if (e_chk.u == 0) begin
        chk("an0", 32'(bus0.anodes), 32'(e_chk.an));
        chk("seg0", 32'(bus0.segs), 32'(e_chk.seg));
        chk("fs0", 32'(bus0.frame_start), 32'(e_chk.fs));
      end else if (e_chk.u == 1) begin
        chk("an1", 32'(bus1.anodes), 32'(e_chk.an));
        chk("seg1", 32'(bus1.segs), 32'(e_chk.seg));
        chk("fs1", 32'(bus1.frame_start), 32'(e_chk.fs));
      end else begin
        chk("an2", 32'(bus2.anodes), 32'(e_chk.an));
        chk("seg2", 32'(bus2.segs), 32'(e_chk.seg));
        chk("fs2", 32'(bus2.frame_start), 32'(e_chk.fs));
      end
    end
  end
  task automatic drive(input int u, input logic [3:0] m, input logic [31:0] d);
    if (u == 0) begin
      bus0.digit_mask = m;
      bus0.digit_data = d;
    end else if (u == 1) begin
      bus1.digit_mask = m;
      bus1.digit_data = d;
    end else begin
      bus2.digit_mask = m[0];
      bus2.digit_data = d[7:0];
    end
  endtask
  task automatic exp(input int u, input logic [3:0] an, input logic [7:0] seg, input logic fs);
    ent_t t;
    t.u   = u;
    t.an  = an;
    t.seg = seg;
    t.fs  = fs;
    sb.push_back(t);
    @(negedge clk);
  endtask
  task automatic lit(input int u, input logic [3:0] an, input logic [7:0] seg, input logic fs, input int n);
    for (int c = 0; c < n; c++) exp(u, an, seg, c == 0 ? fs : 1'b0);
  endtask
  task automatic frame(input int u, input logic [3:0] m, input logic [31:0] d, input logic [31:0] nd);
    int n, dw, bl;
    logic [3:0] off;
    bit first;
    n     = u == 2 ? 1 : 4;
    dw    = u == 2 ? 1 : 3;
    bl    = u == 0 ? 1 : (u == 1 ? 0 : 2);
    off   = u == 1 ? 4'hF : 4'h0;
    first = 1'b1;
    drive(u, m, d);
    for (int i = 0; i < n; i++) begin
      if (!m[i]) begin
        for (int c = 0; c < dw; c++) begin
          exp(u, off ^ (4'b1 << i), d[i*8 +: 8], first);
          if (first) drive(u, m, nd);
          first = 1'b0;
        end
        for (int c = 0; c < bl; c++) exp(u, off, 8'h00, 1'b0);
      end
    end
  endtask
  initial begin
    logic [31:0] d_a, d_b;
    d_a     = 32'h88442211;
    d_b     = 32'h8844FF11;
    rst_n   = 1'b0;
    bus0.en = 1'b1;
    bus1.en = 1'b0;
    bus2.en = 1'b0;
    drive(0, 4'h0, d_a);
    drive(1, 4'h0, d_a);
    drive(2, 4'h0, 32'h5A);
    @(negedge clk);
    lit(0, 4'h0, 8'h00, 1'b0, 3);
    chk("rst_cur0", 32'(bus0.cur_digit), 32'd0);
    chk("rst_an1", 32'(bus1.anodes), 32'hF);
    rst_n = 1'b1;
    frame(0, 4'h0, d_a, d_a);
    frame(0, 4'h0, d_a, d_a);
    frame(0, 4'h0, d_a, d_b);
    frame(0, 4'h0, d_b, d_b);
    frame(0, 4'h5, d_b, d_b);
    frame(0, 4'h5, d_b, d_b);
    drive(0, 4'hF, d_b);
    lit(0, 4'h0, 8'h00, 1'b0, 3);
    drive(0, 4'h0, d_b);
    lit(0, 4'h1, 8'h11, 1'b1, 3);
    lit(0, 4'h0, 8'h00, 1'b0, 1);
    lit(0, 4'h2, 8'hFF, 1'b0, 3);
    lit(0, 4'h0, 8'h00, 1'b0, 1);
    lit(0, 4'h4, 8'h44, 1'b0, 1);
    bus0.en = 1'b0;
    lit(0, 4'h0, 8'h00, 1'b0, 2);
    chk("stop_cur0", 32'(bus0.cur_digit), 32'd2);
    bus0.en = 1'b1;
    lit(0, 4'h1, 8'h11, 1'b1, 3);
    lit(0, 4'h0, 8'h00, 1'b0, 1);
    lit(0, 4'h2, 8'hFF, 1'b0, 3);
    lit(0, 4'h0, 8'h00, 1'b0, 1);
    rst_n = 1'b0;
    lit(0, 4'h0, 8'h00, 1'b0, 2);
    chk("mid_rst_cur0", 32'(bus0.cur_digit), 32'd0);
    rst_n = 1'b1;
    lit(0, 4'h1, 8'h11, 1'b1, 3);
    bus0.en = 1'b0;
    lit(0, 4'h0, 8'h00, 1'b0, 1);
    lit(1, 4'hF, 8'h00, 1'b0, 1);
    bus1.en = 1'b1;
    frame(1, 4'h0, d_a, d_a);
    frame(1, 4'h0, d_a, d_a);
    bus1.en = 1'b0;
    lit(1, 4'hF, 8'h00, 1'b0, 1);
    bus2.en = 1'b1;
    frame(2, 4'h0, 32'h5A, 32'hA5);
    frame(2, 4'h0, 32'hA5, 32'hA5);
    drive(2, 4'h1, 32'hA5);
    lit(2, 4'h0, 8'h00, 1'b0, 2);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
